// File: rtl/sumador_segmentado.sv
// sumador_segmentado: pipelined ripple-carry adder/subtractor,
// one carry slice per stage, valid/ready handshake on both sides.

module sumador_fa #(
  parameter int PwrC = 0
) (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);

  if (PwrC < 0) begin : g_bad_pwrc
    $error("sumador_fa: PwrC must be non-negative");
  end

  assign s  = a ^ b ^ ci;
  assign co = (a & b) | (ci & (a ^ b));

endmodule

module sumador_stage #(
  parameter int WIDTH = 8,
  parameter int L     = 4,
  parameter int K     = 0,
  parameter int PwrC  = 0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             adv,
  input  logic             vi,
  input  logic [WIDTH-1:0] ai,
  input  logic [WIDTH-1:0] bi,
  input  logic [WIDTH-1:0] si,
  input  logic             ci,
  output logic             vo,
  output logic [WIDTH-1:0] ao,
  output logic [WIDTH-1:0] bo,
  output logic [WIDTH-1:0] so,
  output logic             co,
  output logic             cm
);

  localparam int LO = K * L;

  logic [L:0]       cc;
  logic [L-1:0]     sl;
  logic [WIDTH-1:0] sn;

  assign cc[0] = ci;

  for (genvar i = 0; i < L; i++) begin : g_fa
    sumador_fa #(
      .PwrC(PwrC)
    ) u_fa (
      .a (ai[LO+i]),
      .b (bi[LO+i]),
      .ci(cc[i]),
      .s (sl[i]),
      .co(cc[i+1])
    );
  end

  // merge this slice's sum into the partial result
  always_comb begin
    sn = si;
    sn[LO +: L] = sl;
  end

  // valid always advances; data loads only for real items
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vo <= 1'b0;
      ao <= '0;
      bo <= '0;
      so <= '0;
      co <= 1'b0;
      cm <= 1'b0;
    end else if (adv) begin
      vo <= vi;
      if (vi) begin
        ao <= ai;
        bo <= bi;
        so <= sn;
        co <= cc[L];
        cm <= cc[L-1];
      end
    end
  end

endmodule

module sumador_segmentado #(
  parameter int WIDTH  = 8,
  parameter int STAGES = 2,
  parameter int PwrC   = 0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             ci,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] s,
  output logic             co,
  output logic             ovf
);

  localparam int L = WIDTH / STAGES;

  if (WIDTH < 2 || STAGES < 1 || STAGES > WIDTH ||
      (WIDTH % STAGES) != 0) begin : g_bad_param
    $error("sumador_segmentado: illegal WIDTH/STAGES");
  end

  logic             adv;
  logic             v_q [STAGES];
  logic [WIDTH-1:0] a_q [STAGES];
  logic [WIDTH-1:0] b_q [STAGES];
  logic [WIDTH-1:0] s_q [STAGES];
  logic             c_q [STAGES];
  logic             m_q [STAGES];

  assign adv      = !out_valid || out_ready;
  assign in_ready = adv;

  for (genvar k = 0; k < STAGES; k++) begin : g_st
    logic             vi;
    logic             ck;
    logic [WIDTH-1:0] ai;
    logic [WIDTH-1:0] bi;
    logic [WIDTH-1:0] si;

    if (k == 0) begin : g_in
      assign vi = in_valid;
      assign ai = a;
      assign bi = b ^ {WIDTH{sub}};
      assign si = '0;
      assign ck = sub | ci;
    end else begin : g_link
      assign vi = v_q[k-1];
      assign ai = a_q[k-1];
      assign bi = b_q[k-1];
      assign si = s_q[k-1];
      assign ck = c_q[k-1];
    end

    sumador_stage #(
      .WIDTH(WIDTH),
      .L    (L),
      .K    (k),
      .PwrC (PwrC)
    ) u_stage (
      .clk  (clk),
      .rst_n(rst_n),
      .adv  (adv),
      .vi   (vi),
      .ai   (ai),
      .bi   (bi),
      .si   (si),
      .ci   (ck),
      .vo   (v_q[k]),
      .ao   (a_q[k]),
      .bo   (b_q[k]),
      .so   (s_q[k]),
      .co   (c_q[k]),
      .cm   (m_q[k])
    );
  end

  assign out_valid = v_q[STAGES-1];
  assign s         = s_q[STAGES-1];
  assign co        = c_q[STAGES-1];
  assign ovf       = m_q[STAGES-1] ^ c_q[STAGES-1];

endmodule
